// File: rtl/sisc_pkg.sv
// Shared SISC datapath package.
// Holds the default bus widths, the NOOP instruction encoding, the fetch
// timeout default and the fetch FSM state type used by pc_fetch.
package sisc_pkg;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 32;
  localparam int WAIT_MAX_DEF = 15;

  // All-zero word decodes as NOOP; used for reset and for timed-out fetches
  localparam logic [DW_DEF-1:0] NOOP = '0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus.
// Ports (master view, i.e. the fetch unit):
//   req   out  1   fetch request
//   addr  out  AW  fetch address
//   ack   in   1   memory returns rdata this cycle
//   rdata in   DW  instruction word
interface pc_fetch_if #(
  parameter int AW = 16,
  parameter int DW = 32
);

  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC computation for the SISC program counter (purely combinational).
// Ports:
//   use_pc  in   1   1: increment from pc (fetch cycle), 0: increment from ir_pc
//   pc      in   AW  current program counter
//   ir_pc   in   AW  address of the instruction in IR
//   pc_sel  in   1   0: increment, 1: branch target
//   br_sel  in   1   0: relative branch, 1: absolute branch
//   br_imm  in   AW  branch field (two's complement offset or absolute address)
//   npc     out  AW  candidate next PC (wraps modulo 2^AW)
module pc_next_calc #(
  parameter int AW = 16
) (
  input  logic          use_pc,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] ir_pc,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic [AW-1:0] br_imm,
  output logic [AW-1:0] npc
);

  logic [AW-1:0] base;
  logic [AW-1:0] inc;
  logic [AW-1:0] rel;

  // Incrementing from ir_pc outside a fetch cycle makes repeated pc_write
  // idempotent: it always lands on the instruction after the one in IR.
  assign base = use_pc ? pc : ir_pc;
  assign inc  = base + AW'(1);

  // Offset is relative to the next sequential instruction; unsigned add
  // gives the two's complement result with silent wrap.
  assign rel  = ir_pc + AW'(1) + br_imm;

  assign npc  = pc_sel ? (br_sel ? br_imm : rel) : inc;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch unit of the SISC datapath.
// Holds PC, computes increment/branch targets and runs a req/ack fetch from
// instruction memory into IR, stalling ctrl while a fetch is outstanding and
// flagging a sticky error if memory does not answer within WAIT_MAX cycles.
// Ports:
//   clk          in   1   clock, rising edge
//   rst_f        in   1   asynchronous active-low reset
//   pc_rst       in   1   synchronous PC clear
//   pc_write     in   1   commit next PC
//   pc_sel       in   1   0: increment, 1: branch target
//   br_sel       in   1   0: relative, 1: absolute branch
//   ir_load      in   1   start fetch at current PC
//   br_imm       in   AW  branch field of IR
//   imem         if       fetch bus (master: req/addr out, ack/rdata in)
//   ir           out  DW  instruction register
//   ir_pc        out  AW  address of instruction in ir
//   pc           out  AW  program counter
//   fetch_stall  out  1   fetch outstanding, ctrl must hold
//   fetch_err    out  1   sticky fetch timeout flag
module pc_fetch
  import sisc_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  input  logic [AW-1:0] br_imm,
  pc_fetch_if.master    imem,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic [AW-1:0] pc,
  output logic          fetch_stall,
  output logic          fetch_err
);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [AW-1:0] fetch_addr;
  logic [7:0]    wait_cnt;
  logic [AW-1:0] npc;
  logic          fetch_start;
  logic          timeout;

  assign fetch_start = (state == IDLE) && ir_load;
  assign timeout     = (state == WAIT) && !imem.ack && (wait_cnt == 8'(WAIT_MAX - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a zero-wait ack keeps us in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ir_load && !imem.ack) state_nxt = WAIT;
      WAIT: if (imem.ack || timeout)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the request address is latched once WAIT is entered so it
  // stays stable even if pc_rst clears PC meanwhile.
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = pc;
    case (state)
      IDLE: begin
        imem.req  = ir_load;
        imem.addr = pc;
      end
      WAIT: begin
        imem.req  = 1'b1;
        imem.addr = fetch_addr;
      end
      default: begin
        imem.req  = 1'b0;
        imem.addr = pc;
      end
    endcase
  end

  assign fetch_stall = imem.req && !imem.ack;

  pc_next_calc #(.AW(AW)) u_next (
    .use_pc (fetch_start),
    .pc     (pc),
    .ir_pc  (ir_pc),
    .pc_sel (pc_sel),
    .br_sel (br_sel),
    .br_imm (br_imm),
    .npc    (npc)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      fetch_addr <= '0;
      wait_cnt   <= '0;
    end else if (fetch_start && !imem.ack) begin
      fetch_addr <= pc;
      wait_cnt   <= '0;
    end else if (state == WAIT && !imem.ack && !timeout) begin
      wait_cnt   <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ir        <= DW'(NOOP);
      ir_pc     <= '0;
      fetch_err <= 1'b0;
    end else if (fetch_start && imem.ack) begin
      ir        <= imem.rdata;
      ir_pc     <= pc;
    end else if (state == WAIT && imem.ack) begin
      ir        <= imem.rdata;
      ir_pc     <= fetch_addr;
    end else if (timeout) begin
      ir        <= DW'(NOOP);
      ir_pc     <= fetch_addr;
      fetch_err <= 1'b1;
    end
  end

  // A write during a stall is dropped; ctrl holds pc_write until the ack.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)                        pc <= '0;
    else if (pc_rst)                   pc <= '0;
    else if (pc_write && !fetch_stall) pc <= npc;
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the fetch
// unit kept in this file.
module tb_pc_fetch;

  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam int WAIT_MAX = 15;

  logic          clk;
  logic          rst_f;
  logic          pc_rst;
  logic          pc_write;
  logic          pc_sel;
  logic          br_sel;
  logic          ir_load;
  logic [AW-1:0] br_imm;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic [AW-1:0] pc;
  logic          fetch_stall;
  logic          fetch_err;

  pc_fetch_if #(.AW(AW), .DW(DW)) imem ();

  pc_fetch #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .pc_rst      (pc_rst),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .br_sel      (br_sel),
    .ir_load     (ir_load),
    .br_imm      (br_imm),
    .imem        (imem),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .pc          (pc),
    .fetch_stall (fetch_stall),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: outstanding-fetch flag, its address and the number
  // of wait cycles already spent on it.
  int            m_pc;
  int            m_ir_pc;
  logic [DW-1:0] m_ir;
  logic          m_err;
  logic          m_busy;
  int            m_addr;
  int            m_waited;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 0; m_ir_pc = 0; m_ir = '0; m_err = 1'b0;
    m_busy = 1'b0; m_addr = 0; m_waited = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, compare every output
  // with the model, then advance the model across the rising edge.
  task automatic applyStimulus(input logic a_rst, input logic a_write, input logic a_sel,
                               input logic a_br, input logic a_load, input logic [AW-1:0] a_imm,
                               input logic a_ack, input logic [DW-1:0] a_rdata,
                               output logic stall_seen);
    logic exp_req;
    int   exp_addr;
    logic exp_stall;
    int   target;
    int   base;
    @(negedge clk);
    pc_rst = a_rst; pc_write = a_write; pc_sel = a_sel; br_sel = a_br;
    ir_load = a_load; br_imm = a_imm; imem.ack = a_ack; imem.rdata = a_rdata;
    #1;
    exp_req   = m_busy || a_load;
    exp_addr  = m_busy ? m_addr : m_pc;
    exp_stall = exp_req && !a_ack;
    checkOutput("imem_req", 64'(imem.req), 64'(exp_req));
    checkOutput("imem_addr", 64'(imem.addr), 64'(exp_addr));
    checkOutput("fetch_stall", 64'(fetch_stall), 64'(exp_stall));
    checkOutput("pc", 64'(pc), 64'(m_pc));
    checkOutput("ir", 64'(ir), 64'(m_ir));
    checkOutput("ir_pc", 64'(ir_pc), 64'(m_ir_pc));
    checkOutput("fetch_err", 64'(fetch_err), 64'(m_err));
    stall_seen = fetch_stall;

    base = (!m_busy && a_load) ? m_pc : m_ir_pc;
    if (!a_sel)     target = (base + 1) % 65536;
    else if (a_br)  target = int'(a_imm);
    else            target = (m_ir_pc + 1 + int'(a_imm)) % 65536;

    if (!m_busy) begin
      if (a_load && a_ack) begin
        m_ir = a_rdata; m_ir_pc = m_pc;
      end else if (a_load) begin
        m_busy = 1'b1; m_addr = m_pc; m_waited = 0;
      end
    end else if (a_ack) begin
      m_ir = a_rdata; m_ir_pc = m_addr; m_busy = 1'b0;
    end else if (m_waited + 1 == WAIT_MAX) begin
      m_ir = '0; m_ir_pc = m_addr; m_err = 1'b1; m_busy = 1'b0;
    end else begin
      m_waited++;
    end

    if (a_rst)                      m_pc = 0;
    else if (a_write && !exp_stall) m_pc = target;
    @(posedge clk);
  endtask

  logic stall;
  int   stall_cycles;

  initial begin
    rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    ir_load = 1'b0; br_imm = '0; imem.ack = 1'b0; imem.rdata = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1;

    // Reset state and a one-cycle synchronous PC clear
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 0, 32'h0, stall);
    #1;
    checkOutput("reset_pc", 64'(pc), 64'h0);
    checkOutput("reset_ir", 64'(ir), 64'h0);
    checkOutput("reset_err", 64'(fetch_err), 64'h0);

    // Absolute branch to 0x0010, then fetch + increment with zero-wait ack
    applyStimulus(0, 1, 1, 1, 0, 16'h0010, 0, 32'h0, stall);
    applyStimulus(0, 1, 0, 0, 1, 16'h0, 1, 32'h1234_5678, stall);
    checkOutput("zw_stall", 64'(stall), 64'h0);
    #1;
    checkOutput("zw_ir", 64'(ir), 64'h1234_5678);
    checkOutput("zw_ir_pc", 64'(ir_pc), 64'h0010);
    checkOutput("zw_pc", 64'(pc), 64'h0011);

    // Relative branch -4 from ir_pc 0x10, then absolute 0x40
    applyStimulus(0, 1, 1, 0, 0, 16'hFFFC, 0, 32'h0, stall);
    #1 checkOutput("rel_pc", 64'(pc), 64'h000D);
    applyStimulus(0, 1, 1, 1, 0, 16'h0040, 0, 32'h0, stall);
    #1 checkOutput("abs_pc", 64'(pc), 64'h0040);

    // Fetch acknowledged after three stalled cycles, pc_write held
    stall_cycles = 0;
    applyStimulus(0, 1, 0, 0, 1, 16'h0, 0, 32'h0, stall);
    if (stall) stall_cycles++;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 16'h0, 0, 32'h0, stall);
      if (stall) stall_cycles++;
    end
    applyStimulus(0, 1, 0, 0, 0, 16'h0, 1, 32'hCAFE_0001, stall);
    if (stall) stall_cycles++;
    checkOutput("stall_cycles", 64'(stall_cycles), 64'd3);
    #1;
    checkOutput("stall_ir", 64'(ir), 64'hCAFE_0001);
    checkOutput("stall_ir_pc", 64'(ir_pc), 64'h0040);

    // Timeout: no ack at all, then a stray late ack
    applyStimulus(0, 0, 0, 0, 1, 16'h0, 0, 32'h0, stall);
    for (int i = 0; i < WAIT_MAX; i++)
      applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0, stall);
    #1;
    checkOutput("to_err", 64'(fetch_err), 64'h1);
    checkOutput("to_ir", 64'(ir), 64'h0);
    checkOutput("to_req", 64'(imem.req), 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'hDEAD_BEEF, stall);
    #1 checkOutput("late_ack_ir", 64'(ir), 64'h0);

    // PC wrap from 0xFFFF on a fetch cycle
    applyStimulus(0, 1, 1, 1, 0, 16'hFFFF, 0, 32'h0, stall);
    applyStimulus(0, 1, 0, 0, 1, 16'h0, 1, 32'h0000_00AA, stall);
    #1;
    checkOutput("wrap_pc", 64'(pc), 64'h0000);
    checkOutput("wrap_ir_pc", 64'(ir_pc), 64'hFFFF);

    // Randomized run: alternating short-latency and timeout-prone memory
    for (int i = 0; i < 400; i++) begin
      logic slow;
      slow = ((i / 100) % 2) == 1;
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) == 0), 16'($urandom),
                    slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0),
                    $urandom, stall);
    end

    // Asynchronous reset in the middle of a stalled fetch
    applyStimulus(0, 1, 1, 1, 0, 16'h1234, 0, 32'h0, stall);
    applyStimulus(0, 0, 0, 0, 1, 16'h0, 0, 32'h0, stall);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0, stall);
    #3;
    ir_load = 1'b0; pc_write = 1'b0; imem.ack = 1'b0;
    rst_f = 1'b0;
    #1;
    checkOutput("arst_pc", 64'(pc), 64'h0);
    checkOutput("arst_ir", 64'(ir), 64'h0);
    checkOutput("arst_ir_pc", 64'(ir_pc), 64'h0);
    checkOutput("arst_req", 64'(imem.req), 64'h0);
    checkOutput("arst_stall", 64'(fetch_stall), 64'h0);
    checkOutput("arst_err", 64'(fetch_err), 64'h0);
    modelReset();
    @(negedge clk);
    rst_f = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'h5555_AAAA, stall);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0, stall);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
